// File: rtl/byte_queue_pkg.sv
// byte_queue_pkg: shared types and default sizes for the byte queue.
//   q_state_t : enqueue handshake FSM states (IDLE, ACK, HOLD)
//   Q_WIDTH   : default bits per entry
//   Q_DEPTH   : default number of entries (power of two, >= 2)
package byte_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } q_state_t;

  localparam int Q_WIDTH = 8;
  localparam int Q_DEPTH = 8;

endpackage

// File: rtl/queue_mem.sv
// queue_mem: WIDTH x DEPTH storage array for byte_queue.
// The array itself carries no reset; only the registered read data does, so the
// queue output comes up as zero.
// Ports:
//   clock_100KHZ : clock, rising edge
//   reset        : asynchronous active-high reset of the read register only
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_en/rd_addr         : read request; rd_data updates on the next edge
//   rd_data               : registered read data, holds when rd_en=0
module queue_mem
  import byte_queue_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int DEPTH = Q_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock_100KHZ,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock_100KHZ) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/byte_queue.sv
// byte_queue: single-clock byte FIFO fed by the serial deserializer.
// A byte is captured from data_in via the data_ready_in/ack_out handshake and
// served to the consumer on dequeue_in, one cycle after the request.
// Optional build macro: QUEUE_DROP_ON_FULL_EN -- when defined, a byte offered
// while full is acknowledged and discarded, and the sticky overflow_out flag is
// raised. When undefined, a full queue stalls the handshake.
// Ports:
//   clock_100KHZ   : clock, rising edge
//   reset          : asynchronous active-high reset
//   data_in        : byte from the deserializer, valid while data_ready_in=1
//   data_ready_in  : deserializer has a byte pending, held until acknowledged
//   ack_out        : one-cycle pulse, byte captured (or dropped)
//   dequeue_in     : consumer request, sampled every cycle
//   data_out       : head byte, registered
//   data_valid_out : one-cycle pulse, data_out updated by a dequeue
//   len_out        : occupancy 0..DEPTH
//   empty_out      : len_out == 0
//   full_out       : len_out == DEPTH
//   overflow_out   : (QUEUE_DROP_ON_FULL_EN only) sticky drop indicator
module byte_queue
  import byte_queue_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int DEPTH = Q_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock_100KHZ,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_ready_in,
  output logic             ack_out,
  input  logic             dequeue_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid_out,
  output logic [PTR_W:0]   len_out,
  output logic             empty_out,
  output logic             full_out
`ifdef QUEUE_DROP_ON_FULL_EN
  ,
  output logic             overflow_out
`endif
);

  localparam logic [PTR_W:0] LEN_FULL = (PTR_W + 1)'(DEPTH);

  q_state_t         state;
  q_state_t         state_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   len;
  logic             full;
  logic             take;   // handshake accepted this cycle (written or dropped)
  logic             wr_en;  // byte actually stored this cycle
  logic             rd_en;

  assign full  = (len == LEN_FULL);
  assign rd_en = dequeue_in && (len != '0);

  // State register
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. HOLD waits for data_ready_in to fall so the byte that
  // was just acknowledged is not captured a second time.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = ACK;
      ACK:     state_next = HOLD;
      HOLD:    if (!data_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. ack_out is a decode of the registered state, so it is a
  // clean one-cycle pulse in the cycle after the capture edge.
  always_comb begin
    take    = 1'b0;
    wr_en   = 1'b0;
    ack_out = (state == ACK);
    if (state == IDLE && data_ready_in) begin
`ifdef QUEUE_DROP_ON_FULL_EN
      take  = 1'b1;
      wr_en = !full;
`else
      take  = !full;
      wr_en = !full;
`endif
    end
  end

  // Pointers, occupancy and read strobe. A dequeue on a full queue frees space
  // only from the next cycle, since the write decision uses the current len.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      len            <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   len <= len + 1'b1;
        2'b01:   len <= len - 1'b1;
        default: len <= len;
      endcase
    end
  end

`ifdef QUEUE_DROP_ON_FULL_EN
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      overflow_out <= 1'b0;
    end else if (take && !wr_en) begin
      overflow_out <= 1'b1;
    end
  end
`endif

  queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) mem_inst (
    .clock_100KHZ (clock_100KHZ),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_ptr),
    .wr_data      (data_in),
    .rd_en        (rd_en),
    .rd_addr      (rd_ptr),
    .rd_data      (data_out)
  );

  assign len_out   = len;
  assign empty_out = (len == '0);
  assign full_out  = full;

endmodule
